// File: rtl/adder_flit_gen_if.sv
// Flit bus between the adder_flit_gen traffic generator and the adder under test.
// The generator drives the operands, valid and status; the consumer drives ready
// and start.
interface adder_flit_gen_if #(
    parameter int N       = 18,
    parameter int PAYLOAD = 20,
    parameter int NUM_PKT = 10
);
    localparam int PW = $clog2(NUM_PKT + 1);
    localparam int FW = $clog2(PAYLOAD + 1);

    logic          start;
    logic          ready;
    logic [N-1:0]  input1;
    logic [N-1:0]  input2;
    logic          valid;
    logic          busy;
    logic          done;
    logic [PW-1:0] pkt_cnt;
    logic [FW-1:0] flit_cnt;

    modport master (
        input  start, ready,
        output input1, input2, valid, busy, done, pkt_cnt, flit_cnt
    );

    modport slave (
        output start, ready,
        input  input1, input2, valid, busy, done, pkt_cnt, flit_cnt
    );
endinterface

// File: rtl/adder_flit_gen.sv
// adder_flit_gen: deterministic flit generator feeding the adder's two operands.
// Packets of PAYLOAD flits cycle through P1, P2, P0, ... followed by GAP idle
// cycles; NUM_PKT packets make one run, closed by a one-cycle done pulse.
// Optional build macro ADDER_FLIT_GEN_GAP_ZERO_EN: when defined, the operands are
// driven to zero whenever no packet is being sent (GAP, IDLE, DONE).
module adder_flit_gen #(
    parameter int N       = 18,
    parameter int PAYLOAD = 20,
    parameter int GAP     = 7,
    parameter int NUM_PKT = 10,
    parameter int ONES    = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_flit_gen_if.master   bus
);
    localparam int W  = 2 * N;
    localparam int PW = $clog2(NUM_PKT + 1);
    localparam int FW = $clog2(PAYLOAD + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] PAT_P1   = ~(ALL_ONES >> ONES);
    localparam logic [W-1:0] PAT_P2   = ~(ALL_ONES << ONES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Flit value for a pattern index.
    function automatic logic [W-1:0] pattern(input logic [1:0] idx);
        case (idx)
            2'd1:    return PAT_P1;
            2'd2:    return PAT_P2;
            default: return {W{1'b0}};
        endcase
    endfunction

    // Pattern index sequence P0 -> P1 -> P2 -> P0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        if (idx == 2'd2) begin
            return 2'd0;
        end else begin
            return idx + 2'd1;
        end
    endfunction

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  flit_q, flit_d, flit_nxt_s;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [PW-1:0] pkt_q, pkt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [1:0]    idx_q, idx_d, nidx_s;
    logic [GW-1:0] gcnt_q, gcnt_d;

    // Next-state logic: run sequencing, pattern stepping and counters.
    always_comb begin
        state_d    = state_q;
        flit_nxt_s = flit_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pkt_d      = pkt_q;
        fcnt_d     = fcnt_q;
        idx_d      = idx_q;
        gcnt_d     = gcnt_q;
        nidx_s     = next_idx(idx_q);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_SEND;
                    idx_d      = 2'd1;
                    flit_nxt_s = PAT_P1;
                    valid_d    = 1'b1;
                    busy_d     = 1'b1;
                    pkt_d      = {PW{1'b0}};
                    fcnt_d     = {FW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                if (valid_q && bus.ready) begin
                    if (int'(fcnt_q) == PAYLOAD - 1) begin
                        // Last flit of the packet accepted.
                        fcnt_d = {FW{1'b0}};
                        pkt_d  = pkt_q + {{(PW-1){1'b0}}, 1'b1};
                        gcnt_d = {GW{1'b0}};
                        if (GAP == 0) begin
                            if (int'(pkt_q) + 1 < NUM_PKT) begin
                                idx_d      = 2'd1;
                                flit_nxt_s = PAT_P1;
                                valid_d    = 1'b1;
                            end else begin
                                valid_d = 1'b0;
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            valid_d = 1'b0;
                            state_d = S_GAP;
                        end
                    end else begin
                        fcnt_d     = fcnt_q + {{(FW-1){1'b0}}, 1'b1};
                        idx_d      = nidx_s;
                        flit_nxt_s = pattern(nidx_s);
                    end
                end else begin
                    // Stall or no flit: hold everything.
                    state_d = S_SEND;
                end
            end
            S_GAP: begin
                if (int'(gcnt_q) == GAP - 1) begin
                    gcnt_d = {GW{1'b0}};
                    if (int'(pkt_q) < NUM_PKT) begin
                        state_d    = S_SEND;
                        idx_d      = 2'd1;
                        flit_nxt_s = PAT_P1;
                        valid_d    = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    gcnt_d = gcnt_q + {{(GW-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Operand value outside packets: zeroed or held depending on the build.
    always_comb begin
`ifdef ADDER_FLIT_GEN_GAP_ZERO_EN
        if (state_d == S_SEND) begin
            flit_d = flit_nxt_s;
        end else begin
            flit_d = {W{1'b0}};
        end
`else
        flit_d = flit_nxt_s;
`endif
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            flit_q  <= {W{1'b0}};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pkt_q   <= {PW{1'b0}};
            fcnt_q  <= {FW{1'b0}};
            idx_q   <= 2'd0;
            gcnt_q  <= {GW{1'b0}};
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pkt_q   <= pkt_d;
            fcnt_q  <= fcnt_d;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign bus.input1   = flit_q[N-1:0];
    assign bus.input2   = flit_q[W-1:N];
    assign bus.valid    = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pkt_cnt  = pkt_q;
    assign bus.flit_cnt = fcnt_q;
endmodule

// File: tb/tb_adder_flit_gen.sv
// Directed self-checking bench for adder_flit_gen with default parameters.
module tb_adder_flit_gen;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   t;
    int   cnt;

    adder_flit_gen_if #(.N(18), .PAYLOAD(20), .NUM_PKT(10)) bus ();

    adder_flit_gen #(.N(18), .PAYLOAD(20), .GAP(7), .NUM_PKT(10), .ONES(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef ADDER_FLIT_GEN_GAP_ZERO_EN
    localparam logic [17:0] GAP_IN1 = 18'h00000;
    localparam logic [17:0] GAP_IN2 = 18'h00000;
`else
    localparam logic [17:0] GAP_IN1 = 18'h3FFFF;
    localparam logic [17:0] GAP_IN2 = 18'h0003F;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        t++;
    endtask

    // Hand-derived operands for flit number k (1-based) in a packet.
    function automatic logic [35:0] exp_flit(input int k);
        case (k % 3)
            1:       return {18'h3FFFF, 18'h3F000};
            2:       return {18'h0003F, 18'h3FFFF};
            default: return {18'h00000, 18'h00000};
        endcase
    endfunction

    task automatic check_flit(input string tag, input int k);
        logic [35:0] e;
        e = exp_flit(k);
        check_eq({tag, "_in1"}, 64'(bus.input1), 64'(e[17:0]));
        check_eq({tag, "_in2"}, 64'(bus.input2), 64'(e[35:18]));
        check_eq({tag, "_valid"}, 64'(bus.valid), 64'd1);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_in1"}, 64'(bus.input1), 64'd0);
        check_eq({tag, "_in2"}, 64'(bus.input2), 64'd0);
        check_eq({tag, "_valid"}, 64'(bus.valid), 64'd0);
        check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check_eq({tag, "_done"}, 64'(bus.done), 64'd0);
        check_eq({tag, "_pkt"}, 64'(bus.pkt_cnt), 64'd0);
        check_eq({tag, "_flit"}, 64'(bus.flit_cnt), 64'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        t         = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.ready = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // First packet: P1, P2, P0 with one-cycle latency from start.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        t = 0;
        check_flit("f1", 1);
        check_eq("f1_busy", 64'(bus.busy), 64'd1);
        check_eq("f1_fcnt", 64'(bus.flit_cnt), 64'd0);
        tick();
        check_flit("f2", 2);
        check_eq("f2_fcnt", 64'(bus.flit_cnt), 64'd1);
        tick();
        check_flit("f3", 3);
        repeat (17) tick();
        check_flit("f20", 20);
        check_eq("f20_fcnt", 64'(bus.flit_cnt), 64'd19);
        tick();
        check_eq("gap_in1", 64'(bus.input1), 64'(GAP_IN1));
        check_eq("gap_in2", 64'(bus.input2), 64'(GAP_IN2));
        check_eq("gap_pkt", 64'(bus.pkt_cnt), 64'd1);
        check_eq("gap_fcnt", 64'(bus.flit_cnt), 64'd0);
        cnt = 0;
        while (bus.valid == 1'b0 && cnt < 20) begin
            tick();
            cnt++;
        end
        check_eq("gap_len", 64'(cnt), 64'd7);
        check_flit("p2f1", 1);

        // Run to done; a start pulse mid-run must not disturb anything.
        cnt = 0;
        while (bus.done == 1'b0 && cnt < 400) begin
            if (t == 100) bus.start = 1'b1;
            else bus.start = 1'b0;
            tick();
            cnt++;
        end
        bus.start = 1'b0;
        check_eq("done_time", 64'(t), 64'd270);
        check_eq("done_pkt", 64'(bus.pkt_cnt), 64'd10);
        check_eq("done_busy", 64'(bus.busy), 64'd0);
        check_eq("done_valid", 64'(bus.valid), 64'd0);
        tick();
        check_eq("done_pulse", 64'(bus.done), 64'd0);
        check_eq("idle_pkt", 64'(bus.pkt_cnt), 64'd10);

        // Restart clears pkt_cnt; then stall on flit 4.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("rs_pkt", 64'(bus.pkt_cnt), 64'd0);
        check_flit("rs_f1", 1);
        repeat (3) tick();
        check_flit("st_f4", 4);
        bus.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_flit("stall", 4);
            check_eq("stall_fcnt", 64'(bus.flit_cnt), 64'd3);
        end
        bus.ready = 1'b1;
        tick();
        check_flit("st_f5", 5);
        check_eq("st_f5_fcnt", 64'(bus.flit_cnt), 64'd4);

        // Reset at the 10th flit of packet 3.
        cnt = 0;
        while (!(bus.pkt_cnt == 4'd2 && bus.flit_cnt == 5'd9 && bus.valid == 1'b1) && cnt < 300) begin
            tick();
            cnt++;
        end
        check_eq("p3f10_reached", 64'(cnt < 300), 64'd1);
        check_flit("p3f10", 10);
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_zero("post_rst");
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_flit("rr_f1", 1);
        check_eq("rr_pkt", 64'(bus.pkt_cnt), 64'd0);
        repeat (27) tick();
        check_flit("rr_p2f1", 1);
        check_eq("rr_pkt1", 64'(bus.pkt_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
